// File: rtl/spectrum_decision.sv
`default_nettype none
// ============================================================================
// Module   : spectrum_decision
// Purpose  : Sliding-window majority vote with hysteresis over detector verdicts.
// Revision : 1.0 - initial release
// ============================================================================
module spectrum_decision #(
  parameter int NWIN = 8,
  parameter int KON  = 5,
  parameter int KOFF = 2,
  parameter int CW   = $clog2(NWIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          det_valid,
  input  logic          detected,
  input  logic          clear,
  output logic          occupied,
  output logic [CW-1:0] vote_count,
  output logic          dec_valid,
  output logic          change
);

  if (KOFF < 0 || KOFF >= KON || KON > NWIN) begin : g_bad_params
    $error("spectrum_decision: parameters must satisfy 0 <= KOFF < KON <= NWIN");
  end

  localparam logic [0:0]    c_fill     = 1'b0;
  localparam logic [0:0]    c_track    = 1'b1;
  localparam logic [CW-1:0] c_kon      = CW'(KON);
  localparam logic [CW-1:0] c_koff     = CW'(KOFF);
  localparam logic [CW-1:0] c_nwin_m1  = CW'(NWIN - 1);

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic [NWIN-1:0] r_hist;
  logic [NWIN-1:0] w_hist_shift;
  logic [CW-1:0]   r_fill;
  logic [CW-1:0]   r_vote_count;
  logic [CW-1:0]   w_count_next;
  logic            r_occupied;
  logic            r_dec_valid;
  logic            r_change;
  logic            w_accept;
  logic            w_fill_last;
  logic            w_evict;
  logic            w_eval;
  logic            w_occ_next;

  // Newest verdict enters bit 0; bit NWIN-1 is the one evicted next.
  if (NWIN == 1) begin : g_shift_single
    assign w_hist_shift = detected;
  end else begin : g_shift_multi
    assign w_hist_shift = {r_hist[NWIN-2:0], detected};
  end

  assign w_accept     = det_valid & ~clear;
  assign w_fill_last  = (r_state == c_fill) && (r_fill == c_nwin_m1);
  assign w_evict      = (r_state == c_track) ? r_hist[NWIN-1] : 1'b0;
  assign w_count_next = r_vote_count + CW'(detected) - CW'(w_evict);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_fill;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = c_fill;
    end else if (det_valid && w_fill_last) begin
      w_state_next = c_track;
    end
  end

  always_comb begin
    w_eval     = w_accept && ((r_state == c_track) || w_fill_last);
    w_occ_next = r_occupied;
    if (w_eval) begin
      if (!r_occupied && (w_count_next >= c_kon)) begin
        w_occ_next = 1'b1;
      end else if (r_occupied && (w_count_next <= c_koff)) begin
        w_occ_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_hist       <= '0;
      r_fill       <= '0;
      r_vote_count <= '0;
      r_occupied   <= 1'b0;
      r_dec_valid  <= 1'b0;
      r_change     <= 1'b0;
    end else begin
      r_dec_valid <= w_eval;
      r_change    <= w_eval && (w_occ_next != r_occupied);
      if (w_accept) begin
        r_hist       <= w_hist_shift;
        r_vote_count <= w_count_next;
        r_occupied   <= w_occ_next;
        if (r_state == c_fill) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  assign occupied   = r_occupied;
  assign vote_count = r_vote_count;
  assign dec_valid  = r_dec_valid;
  assign change     = r_change;

endmodule
`default_nettype wire
